// File: rtl/pixel_frame_writer.sv
// ============================================================================
// Module      : pixel_frame_writer
// Description : Two-wire LED controller frame writer: start, N acked words,
//               stop, fed by a one-word valid/ready holding register.
//               Optional macro ACK_CHECK_EN enables the missing-ack pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_frame_writer #(
  parameter int CLK_IN_HZ   = 12_000_000,
  parameter int BIT_RATE_HZ = 250_000,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_WORDS   = 16,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid,
  input  logic [DATA_WIDTH-1:0]              value,
  input  logic                               last,
  output logic                               ready,
  output logic                               d_clk,
  output logic                               d_out,
  output logic                               d_oe,
  input  logic                               d_in,
  output logic                               busy,
  output logic [$clog2(MAX_WORDS+1)-1:0]     word_count,
  output logic                               ack_err
);

  localparam int DIV = CLK_IN_HZ / (4 * BIT_RATE_HZ);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int WCW = $clog2(MAX_WORDS + 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("pixel_frame_writer: CLK_IN_HZ/(4*BIT_RATE_HZ) must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_HOLD  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_phase;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_full;
  logic                  r_hold_last;
  logic                  r_cur_last;
  logic [WCW-1:0]        r_wc;
  logic                  r_d_clk;
  logic                  r_d_out;
  logic                  r_d_oe;
  logic                  r_busy;
  logic                  r_ack_err;

  logic                  w_tick;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_next_bit;
  logic                  w_load_bit;
  logic [WCW-1:0]        w_wc_inc;
  logic                  w_frame_end;
  logic                  w_load;

  assign w_tick      = (r_cnt == CW'(DIV - 1));
  assign w_shift_nxt = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
  assign w_next_bit  = LSB_FIRST ? w_shift_nxt[0] : w_shift_nxt[DATA_WIDTH-1];
  assign w_load_bit  = LSB_FIRST ? r_hold_data[0] : r_hold_data[DATA_WIDTH-1];
  assign w_wc_inc    = r_wc + WCW'(1);
  assign w_frame_end = r_cur_last || (w_wc_inc == WCW'(MAX_WORDS));

  // Shifter loads: end of START, back-to-back after ACK, or leaving HOLD.
  assign w_load = ((r_state == S_START) && w_tick && (r_phase == 2'd1)) ||
                  ((r_state == S_ACK) && w_tick && (r_phase == 2'd3) &&
                   !w_frame_end && r_hold_full) ||
                  ((r_state == S_HOLD) && r_hold_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phase     <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_cur_last  <= 1'b0;
      r_wc        <= '0;
      r_d_clk     <= 1'b1;
      r_d_out     <= 1'b1;
      r_d_oe      <= 1'b1;
      r_busy      <= 1'b0;
      r_ack_err   <= 1'b0;
    end else begin
      r_busy    <= (r_state != S_IDLE) || r_hold_full;
      r_ack_err <= 1'b0;

      if (valid && !r_hold_full) begin
        r_hold_data <= value;
        r_hold_last <= last;
        r_hold_full <= 1'b1;
      end

      if ((r_state == S_IDLE) || (r_state == S_HOLD) || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);

      case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            r_state <= S_START;
            r_phase <= 2'd0;
            r_wc    <= '0;
            r_d_out <= 1'b0;
            r_d_clk <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick && (r_phase == 2'd0)) begin
            r_phase <= 2'd1;
            r_d_clk <= 1'b0;
          end
        end
        S_BIT: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd1) r_d_clk <= 1'b1;
            if (r_phase == 2'd3) begin
              r_d_clk <= 1'b0;
              if (r_bit == BW'(DATA_WIDTH - 1)) begin
                r_state <= S_ACK;
                r_d_oe  <= 1'b0;
                r_d_out <= 1'b1;
              end else begin
                r_bit   <= r_bit + BW'(1);
                r_shift <= w_shift_nxt;
                r_d_out <= w_next_bit;
              end
            end
          end
        end
        S_ACK: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd1) r_d_clk <= 1'b1;
`ifdef ACK_CHECK_EN
            if ((r_phase == 2'd2) && d_in) r_ack_err <= 1'b1;
`endif
            if (r_phase == 2'd3) begin
              r_wc   <= w_wc_inc;
              r_d_oe <= 1'b1;
              if (w_frame_end) begin
                r_state <= S_STOP;
                r_d_clk <= 1'b0;
                r_d_out <= 1'b0;
              end else if (!r_hold_full) begin
                r_state <= S_HOLD;
                r_d_clk <= 1'b0;
                r_d_out <= 1'b0;
              end
            end
          end
        end
        S_HOLD: begin
          r_d_clk <= 1'b0;
          r_d_out <= 1'b0;
        end
        S_STOP: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd0) r_d_clk <= 1'b1;
            if (r_phase == 2'd1) r_d_out <= 1'b1;
            if (r_phase == 2'd2) begin
              r_state <= S_IDLE;
              r_phase <= 2'd0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Placed after the case so a load overrides the per-state updates.
      if (w_load) begin
        r_shift     <= r_hold_data;
        r_cur_last  <= r_hold_last;
        r_hold_full <= 1'b0;
        r_d_out     <= w_load_bit;
        r_d_clk     <= 1'b0;
        r_phase     <= 2'd0;
        r_bit       <= '0;
        r_state     <= S_BIT;
      end
    end
  end

`ifndef ACK_CHECK_EN
  logic w_unused_din;
  assign w_unused_din = d_in;
`endif

  assign ready      = ~r_hold_full;
  assign d_clk      = r_d_clk;
  assign d_out      = r_d_out;
  assign d_oe       = r_d_oe;
  assign busy       = r_busy;
  assign word_count = r_wc;
  assign ack_err    = r_ack_err;

endmodule

`default_nettype wire

// File: tb/tb_pixel_frame_writer.sv
// ============================================================================
// Module      : tb_pixel_frame_writer
// Description : Directed bench for pixel_frame_writer; a bus decoder rebuilds
//               words from d_clk/d_out and checks framing and timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_frame_writer;

`ifdef ACK_CHECK_EN
  localparam int EXP_AE = 1;
`else
  localparam int EXP_AE = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] vld, lst, rdy, dclk, dout, doe, din, bsy, aerr;
  logic [7:0] val0, val1;
  logic [4:0] wc0;
  logic [2:0] wc1;

  pixel_frame_writer u_dut (
    .clk(clk), .rst(rst), .valid(vld[0]), .value(val0), .last(lst[0]),
    .ready(rdy[0]), .d_clk(dclk[0]), .d_out(dout[0]), .d_oe(doe[0]),
    .d_in(din[0]), .busy(bsy[0]), .word_count(wc0), .ack_err(aerr[0])
  );

  // Fast, MSB-first, four-word-limit variant.
  pixel_frame_writer #(
    .CLK_IN_HZ(12_000_000), .BIT_RATE_HZ(750_000), .DATA_WIDTH(8),
    .MAX_WORDS(4), .LSB_FIRST(1'b0)
  ) u_dut4 (
    .clk(clk), .rst(rst), .valid(vld[1]), .value(val1), .last(lst[1]),
    .ready(rdy[1]), .d_clk(dclk[1]), .d_out(dout[1]), .d_oe(doe[1]),
    .d_in(din[1]), .busy(bsy[1]), .word_count(wc1), .ack_err(aerr[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  int         starts[2], stops[2], acks[2], nbits[2], nw[2];
  int         bit_err[2], line_err[2], rdy_rise[2], ae_hi[2], ae_rise[2];
  logic [7:0] sh[2];
  logic [7:0] wlog[2][16];
  logic       p_clk[2], p_out[2], p_rdy[2], p_ae[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        p_clk[k] = 1'b1; p_out[k] = 1'b1; p_rdy[k] = 1'b1; p_ae[k] = 1'b0;
        nbits[k] = 0;
      end else begin
        if (p_clk[k] && dclk[k] && p_out[k] && !dout[k]) begin
          starts[k]++;
          nbits[k] = 0;
        end
        if (p_clk[k] && dclk[k] && !p_out[k] && dout[k]) stops[k]++;
        if (!p_clk[k] && dclk[k]) begin
          if (doe[k]) begin
            sh[k] = {dout[k], sh[k][7:1]};
            nbits[k]++;
          end else begin
            if (nbits[k] != 8) bit_err[k]++;
            if (nw[k] < 16) begin
              wlog[k][nw[k]] = (k == 0) ? sh[k] : rev8(sh[k]);
              nw[k]++;
            end
            acks[k]++;
            nbits[k] = 0;
          end
        end
        if (!doe[k] && !dout[k]) line_err[k]++;
        if (rdy[k] && !p_rdy[k]) rdy_rise[k]++;
        if (aerr[k]) ae_hi[k]++;
        if (aerr[k] && !p_ae[k]) ae_rise[k]++;
        p_clk[k] = dclk[k]; p_out[k] = dout[k]; p_rdy[k] = rdy[k]; p_ae[k] = aerr[k];
      end
    end
  end

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      starts[k] = 0; stops[k] = 0; acks[k] = 0; nbits[k] = 0; nw[k] = 0;
      bit_err[k] = 0; line_err[k] = 0; rdy_rise[k] = 0; ae_hi[k] = 0; ae_rise[k] = 0;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after capture.
  task automatic push(input int k, input logic [7:0] v, input logic l);
    int n = 0;
    vld[k] = 1'b1;
    lst[k] = l;
    if (k == 0) val0 = v; else val1 = v;
    while (rdy[k] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_val("push_timeout", rdy[k], 1);
    @(negedge clk);
    vld[k] = 1'b0;
    lst[k] = 1'b0;
  endtask

  // Cycles from the first START sample until busy reads low.
  task automatic measure(input int k, output int t);
    int n = 0;
    t = 0;
    while (dout[k] !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    while (bsy[k] !== 1'b0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (bsy[k] !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_reached", bsy[k], 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int t;
    int hold_bad;
    int busy_bad;
    int n;
    logic [7:0] exp4 [6];
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rst = 1'b1; vld = '0; lst = '0; val0 = '0; val1 = '0; din = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_val("rst_dclk", dclk, 2'b11);
    check_val("rst_dout", dout, 2'b11);
    check_val("rst_doe", doe, 2'b11);
    check_val("rst_ready", rdy, 2'b11);
    check_val("rst_busy", bsy, 2'b00);
    check_val("rst_ackerr", aerr, 2'b00);
    check_val("rst_wc", wc0, 0);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();

    // Single word 0xA5: 492 cycles START..IDLE, busy falls one cycle later.
    fork
      push(0, 8'hA5, 1'b1);
      measure(0, t);
    join
    check_val("one_cycles", t, 493);
    check_val("one_nw", nw[0], 1);
    check_val("one_word", wlog[0][0], 8'hA5);
    check_val("one_starts", starts[0], 1);
    check_val("one_stops", stops[0], 1);
    check_val("one_wc", wc0, 1);
    check_val("one_rdyrise", rdy_rise[0], 1);
    check_val("one_biterr", bit_err[0], 0);
    check_val("one_ackline", line_err[0], 0);
    check_val("one_ackerr", ae_rise[0], 0);

    // Three back-to-back words: (2 + 3*36 + 3) phases with no HOLD.
    clear_mon();
    fork
      begin
        push(0, 8'h40, 1'b0);
        push(0, 8'hC0, 1'b0);
        push(0, 8'h8F, 1'b1);
      end
      measure(0, t);
    join
    check_val("three_cycles", t, 1357);
    check_val("three_nw", nw[0], 3);
    check_val("three_w0", wlog[0][0], 8'h40);
    check_val("three_w1", wlog[0][1], 8'hC0);
    check_val("three_w2", wlog[0][2], 8'h8F);
    check_val("three_starts", starts[0], 1);
    check_val("three_stops", stops[0], 1);
    check_val("three_wc", wc0, 3);
    check_val("three_rdyrise", rdy_rise[0], 3);
    check_val("three_biterr", bit_err[0], 0);

    // Stall: frame stretches in HOLD until the second word arrives.
    clear_mon();
    push(0, 8'h3C, 1'b0);
    n = 0;
    while (acks[0] < 1 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check_val("stall_ack", acks[0], 1);
    repeat (30) @(negedge clk);
    hold_bad = 0;
    busy_bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (dclk[0] !== 1'b0 || dout[0] !== 1'b0) hold_bad++;
      if (bsy[0] !== 1'b1) busy_bad++;
      @(negedge clk);
    end
    check_val("stall_hold_lines", hold_bad, 0);
    check_val("stall_busy", busy_bad, 0);
    push(0, 8'h81, 1'b1);
    check_val("stall_pre_resume", dout[0], 0);
    @(negedge clk);
    check_val("stall_resume_dout", dout[0], 1);
    check_val("stall_resume_dclk", dclk[0], 0);
    wait_idle(0);
    check_val("stall_w0", wlog[0][0], 8'h3C);
    check_val("stall_w1", wlog[0][1], 8'h81);
    check_val("stall_starts", starts[0], 1);
    check_val("stall_stops", stops[0], 1);
    check_val("stall_wc", wc0, 2);

    // Word limit of 4 on the MSB-first instance; fifth word opens a new frame.
    clear_mon();
    fork
      begin
        for (int i = 0; i < 5; i++) push(1, exp4[i], 1'b0);
      end
      begin
        n = 0;
        while (stops[1] < 1 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        check_val("max_wc_at_stop", wc1, 4);
        check_val("max_acks_at_stop", acks[1], 4);
        n = 0;
        while (starts[1] < 2 && n < 500) begin
          @(negedge clk);
          n++;
        end
        check_val("max_wc_restart", wc1, 0);
        n = 0;
        while (acks[1] < 5 && n < 1000) begin
          @(negedge clk);
          n++;
        end
        repeat (12) @(negedge clk);
        check_val("max_wc_after5", wc1, 1);
      end
    join
    push(1, 8'h66, 1'b1);
    wait_idle(1);
    check_val("max_nw", nw[1], 6);
    for (int i = 0; i < 6; i++) check_val($sformatf("max_w%0d", i), wlog[1][i], exp4[i]);
    check_val("max_starts", starts[1], 2);
    check_val("max_stops", stops[1], 2);
    check_val("max_wc_end", wc1, 2);
    check_val("max_biterr", bit_err[1], 0);

    // Asynchronous reset while d_clk is high in the third bit.
    clear_mon();
    push(0, 8'h5A, 1'b1);
    n = 0;
    while (nbits[0] < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val("arst_bit3_seen", nbits[0], 3);
    #2 rst = 1'b1;
    #1;
    check_val("arst_dclk", dclk[0], 1);
    check_val("arst_dout", dout[0], 1);
    check_val("arst_doe", doe[0], 1);
    check_val("arst_ready", rdy[0], 1);
    check_val("arst_busy", bsy[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    fork
      push(0, 8'hC3, 1'b1);
      measure(0, t);
    join
    check_val("arst_next_cycles", t, 493);
    check_val("arst_next_word", wlog[0][0], 8'hC3);
    check_val("arst_next_starts", starts[0], 1);
    check_val("arst_next_stops", stops[0], 1);
    check_val("arst_next_wc", wc0, 1);

    // Missing ack: d_in high through the frame.
    clear_mon();
    din[0] = 1'b1;
    fork
      push(0, 8'h0F, 1'b1);
      measure(0, t);
    join
    din[0] = 1'b0;
    check_val("nak_pulses", ae_rise[0], EXP_AE);
    check_val("nak_high_cycles", ae_hi[0], EXP_AE);
    check_val("nak_cycles", t, 493);
    check_val("nak_word", wlog[0][0], 8'h0F);
    check_val("nak_stops", stops[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pixel_frame_writer.md
Name: pixel_frame_writer

Overview:
Parametrised successor to the single-byte two-wire LED driver writer. Sends multi-byte frames over the two-wire LED controller interface (d_clk/d_out). Each frame has one start condition, N words with a 9th acknowledge clock after each word, and one stop condition. Sits between the display-refresh controller, which pushes command and pixel bytes through a valid/ready handshake, and the PMod pins.

Parameters:
CLK_IN_HZ, 12_000_000, system clock frequency.
BIT_RATE_HZ, 250_000, serial bit rate. Phase length DIV = CLK_IN_HZ/(4*BIT_RATE_HZ) clk cycles; default 12. Elaboration error if DIV < 1.
DATA_WIDTH, 8, bits per word.
MAX_WORDS, 16, maximum words per frame; forces a stop when reached.
LSB_FIRST, 1, 1 = bit 0 sent first; 0 = MSB first.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
valid  in  1  word offered
value  in  DATA_WIDTH  word to send
last  in  1  word is final in frame; qualified by valid
ready  out  1  holding register empty; accept when valid&&ready
d_clk  out  1  serial clock pin
d_out  out  1  serial data pin value
d_oe  out  1  1 = drive d_out; 0 = release line for ack
d_in  in  1  data pin readback
busy  out  1  frame in progress or word pending
word_count  out  $clog2(MAX_WORDS+1)  words sent in current frame
ack_err  out  1  one-cycle pulse on missing ack

Behaviour:
- Reset (async, rst=1): d_clk=1, d_out=1, d_oe=1, ready=1, busy=0, ack_err=0, word_count=0. Holding register is emptied, FSM goes to IDLE, phase counter is cleared. A reset mid-frame aborts with no stop condition.
- Holding register: one word plus its last flag.
  - Captured on valid&&ready, so ready=0 from the next cycle.
  - Freed on the cycle the shifter loads it, at the start of the first bit of that word.
  - With valid held high, a new word is accepted the cycle after the free.
- Phase timing: the FSM advances only when the phase counter reaches DIV-1. Each phase lasts exactly DIV clk cycles. The counter restarts at 0 on leaving IDLE.
- IDLE: d_clk=1, d_out=1, d_oe=1. On the first cycle with the holding register full, go to START; no tick alignment.
- START (2 phases): phase 0 d_out=0, d_clk=1; phase 1 d_out=0, d_clk=0. Clear word_count, load the shifter, go to BIT.
- BIT (4 phases per bit, DATA_WIDTH bits):
  - p0 set d_out to the current bit with d_clk=0; p1 d_clk=0; p2 d_clk=1; p3 d_clk=1.
  - d_out is stable for all 4 phases.
  - Bit order follows LSB_FIRST.
- ACK (4 phases): d_oe=0 and d_out=1 throughout; d_clk pattern as BIT. At the end of ACK, increment word_count.
- Decision after ACK:
  - If the loaded word had last=1, or word_count==MAX_WORDS, go to STOP.
  - Otherwise, if the holding register is full, load it and go to BIT.
  - Otherwise go to HOLD.
- HOLD: d_clk=0, d_out=0, d_oe=1, held indefinitely (clock stretch). Leave for BIT one cycle after the holding register fills; no glitch on d_clk.
- STOP (3 phases): p0 d_clk=0, d_out=0; p1 d_clk=1, d_out=0; p2 d_clk=1, d_out=1. Then go to IDLE; word_count holds until the next START.
- MAX_WORDS reached without last: the frame is stopped. A pending word, or the next word, opens a new frame.
- busy = (state != IDLE) || holding register full. It is registered, so it lags a state change by 1 cycle.
- Default single-word frame: 2+36+3 = 41 phases = 492 clk cycles from leaving IDLE to returning to IDLE.

Optional Feature:
ACK_CHECK_EN.
- Defined: d_in is sampled on the last cycle of ACK p2. If it reads 1, ack_err pulses high for 1 cycle and the frame continues unchanged.
- Undefined: d_in is ignored and ack_err is tied 0.
- ACK timing and d_oe=0 during ACK are identical in both builds.

Test Plan:
- Single word, default params: value=0xA5, last=1 -> start, d_out bits 1,0,1,0,0,1,0,1 on d_clk rising edges, 9th clock with d_oe=0, stop. Back to IDLE after 492 cycles; word_count=1.
- Three words, valid held: 0x40, 0xC0, 0x8F (last on 3rd) -> one START, 3×36 phases contiguous with no HOLD, one STOP; word_count=3; ready drops then rises once per word.
- Stall: second word presented 200 cycles after the first ACK -> HOLD with d_clk=0 and d_out=0 steady for the whole wait. BIT resumes 1 cycle after capture; busy stays 1.
- MAX_WORDS=4, 5 words with no last -> STOP after the 4th word. The 5th word gets a fresh START; word_count resets to 0 then reaches 1.
- Async reset asserted in BIT p2 of the 3rd bit -> the same cycle shows d_clk=1, d_out=1, d_oe=1, ready=1, busy=0. A next word after reset sends a full frame correctly.
- ACK_CHECK_EN built: d_in=1 during ACK -> ack_err pulses 1 cycle and the frame completes. Same stimulus without the macro -> ack_err stays 0.
